// File: rtl/fetch_responder_if.sv
// rtl/fetch_responder_if.sv - fetch request/response and memory read signal bundle for fetch_responder
interface fetch_responder_if #(
  parameter int RW     = 16,
  parameter int I_SIZE = 2 * RW
);
  logic [RW-1:0]     i_req_addr;
  logic              i_req_submit;
  logic [I_SIZE-1:0] o_req_data;
  logic              o_req_data_valid;
  logic [RW-1:0]     o_mem_addr;
  logic              o_mem_req;
  logic [RW-1:0]     i_mem_data;
  logic              i_mem_ack;

  modport slave (
    input  i_req_addr, i_req_submit, i_mem_data, i_mem_ack,
    output o_req_data, o_req_data_valid, o_mem_addr, o_mem_req
  );

  modport master (
    output i_req_addr, i_req_submit, i_mem_data, i_mem_ack,
    input  o_req_data, o_req_data_valid, o_mem_addr, o_mem_req
  );
endinterface

// File: rtl/fetch_responder.sv
// rtl/fetch_responder.sv - queued instruction fetch responder, two 16-bit reads per instruction
// Optional build macro FETCH_RESP_BYPASS_EN: idle-and-empty submits start the low read one cycle early.
module fetch_responder #(
  parameter int RW     = 16,
  parameter int I_SIZE = 32,
  parameter int DEPTH  = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  fetch_responder_if.slave  bus,
  output logic              o_overflow,
  output logic              o_busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, RD_LO, RD_HI} state_t;

  state_t            state, state_nx;
  logic [RW-2:0]     fifo [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr, rd_ptr_inc;
  logic [CW-1:0]     count, count_nx;
  logic [RW-2:0]     head, next_head;
  logic              full, push, pop;
  logic [RW-1:0]     lo_reg;
  logic [RW-1:0]     mem_addr, mem_addr_nx;
  logic              mem_req;
  logic [I_SIZE-1:0] data_r;
  logic              valid_r;

  assign full       = (count == CW'(DEPTH));
  assign pop        = (state == RD_HI) && bus.i_mem_ack;
  // A pop in the same cycle frees the slot, so a submit on a full queue still fits.
  assign push       = bus.i_req_submit && (!full || pop);
  assign rd_ptr_inc = rd_ptr + 1'b1;
  assign head       = fifo[rd_ptr];
  // With one entry left, the entry after the pop is the one arriving this cycle.
  assign next_head  = (count == CW'(1)) ? bus.i_req_addr[RW-2:0] : fifo[rd_ptr_inc];

  always_comb begin
    count_nx = count;
    case ({push, pop})
      2'b10:   count_nx = count + 1'b1;
      2'b01:   count_nx = count - 1'b1;
      default: count_nx = count;
    endcase
  end

  always_comb begin
    state_nx    = state;
    mem_addr_nx = mem_addr;
    case (state)
      IDLE: begin
`ifdef FETCH_RESP_BYPASS_EN
        if (count == '0 && bus.i_req_submit) begin
          state_nx    = RD_LO;
          mem_addr_nx = {bus.i_req_addr[RW-2:0], 1'b0};
        end else
`endif
        if (count != '0) begin
          state_nx    = RD_LO;
          mem_addr_nx = {head, 1'b0};
        end
      end
      RD_LO: begin
        if (bus.i_mem_ack) begin
          state_nx    = RD_HI;
          mem_addr_nx = {head, 1'b1};
        end
      end
      RD_HI: begin
        if (bus.i_mem_ack) begin
          if (count_nx != '0) begin
            state_nx    = RD_LO;
            mem_addr_nx = {next_head, 1'b0};
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (push) fifo[wr_ptr] <= bus.i_req_addr[RW-2:0];
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      lo_reg     <= '0;
      mem_addr   <= '0;
      mem_req    <= 1'b0;
      data_r     <= '0;
      valid_r    <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      state    <= state_nx;
      count    <= count_nx;
      mem_addr <= mem_addr_nx;
      mem_req  <= (state_nx != IDLE);
      valid_r  <= pop;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr_inc;
        data_r <= {bus.i_mem_data, lo_reg};
      end
      if (state == RD_LO && bus.i_mem_ack) lo_reg <= bus.i_mem_data;
      if (bus.i_req_submit && full && !pop) o_overflow <= 1'b1;
    end
  end

  assign bus.o_mem_req        = mem_req;
  assign bus.o_mem_addr       = mem_addr;
  assign bus.o_req_data       = data_r;
  assign bus.o_req_data_valid = valid_r;
  assign o_busy               = (count != '0) || (state != IDLE);
endmodule

// File: tb/tb_fetch_responder.sv
// tb/tb_fetch_responder.sv - table-driven and sequence checks for fetch_responder
module tb_fetch_responder;
`ifdef FETCH_RESP_BYPASS_EN
  localparam int EXP_LAT = 4;
`else
  localparam int EXP_LAT = 5;
`endif

  logic i_clk = 1'b0;
  logic i_rst = 1'b0;
  logic o_overflow, o_busy;
  logic m_ack = 1'b0;
  logic stray_ack = 1'b0;
  logic hold_ack = 1'b0;
  logic [15:0] m_data = '0;

  int total = 0;
  int bad = 0;
  logic [31:0] resp_q [$];
  logic [15:0] addr_log [$];

  fetch_responder_if #(.RW(16)) bus ();

  fetch_responder #(.RW(16), .I_SIZE(32), .DEPTH(4)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .bus        (bus),
    .o_overflow (o_overflow),
    .o_busy     (o_busy)
  );

  always #5 i_clk = ~i_clk;

  assign bus.i_mem_ack  = m_ack | stray_ack;
  assign bus.i_mem_data = m_data;

  function automatic logic [15:0] mem_fn(input logic [15:0] a);
    if (a == 16'h0020) return 16'h1234;
    if (a == 16'h0021) return 16'hABCD;
    return a;
  endfunction

  // Registered single-outstanding memory: acks one cycle after it sees req.
  always @(posedge i_clk) begin
    if (!i_rst) begin
      m_ack <= 1'b0;
    end else if (m_ack) begin
      m_ack <= 1'b0;
    end else if (bus.o_mem_req && !hold_ack) begin
      m_ack  <= 1'b1;
      m_data <= mem_fn(bus.o_mem_addr);
      addr_log.push_back(bus.o_mem_addr);
    end
  end

  always @(negedge i_clk) begin
    if (bus.o_req_data_valid) resp_q.push_back(bus.o_req_data);
  end

  typedef struct {
    logic [15:0] addr;
    logic [15:0] lo_addr;
    logic [15:0] hi_addr;
    logic [31:0] data;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic wait_resp(input int n, input int budget);
    int c = 0;
    while (resp_q.size() < n && c < budget) begin
      @(negedge i_clk);
      c++;
    end
    check("resp_wait", resp_q.size(), n);
  endtask

  task automatic submit(input logic [15:0] a);
    @(negedge i_clk);
    bus.i_req_submit = 1'b1;
    bus.i_req_addr   = a;
    @(negedge i_clk);
    bus.i_req_submit = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_rst = 1'b0;
    hold_ack = 1'b0;
    repeat (2) @(negedge i_clk);
    i_rst = 1'b1;
  endtask

  initial begin
    int base, abase, lat, c;
    bus.i_req_addr   = '0;
    bus.i_req_submit = 1'b0;
    vecs[0] = '{16'h0010, 16'h0020, 16'h0021, 32'hABCD1234};
    vecs[1] = '{16'h8005, 16'h000A, 16'h000B, 32'h000B000A};
    vecs[2] = '{16'h0000, 16'h0000, 16'h0001, 32'h00010000};
    vecs[3] = '{16'hFFFF, 16'hFFFE, 16'hFFFF, 32'hFFFFFFFE};
    vecs[4] = '{16'h7FFF, 16'hFFFE, 16'hFFFF, 32'hFFFFFFFE};
    vecs[5] = '{16'h1234, 16'h2468, 16'h2469, 32'h24692468};

    repeat (3) @(negedge i_clk);
    check("rst_mem_req", bus.o_mem_req, 0);
    check("rst_mem_addr", bus.o_mem_addr, 0);
    check("rst_valid", bus.o_req_data_valid, 0);
    check("rst_data", bus.o_req_data, 0);
    check("rst_overflow", o_overflow, 0);
    check("rst_busy", o_busy, 0);
    i_rst = 1'b1;
    repeat (2) @(negedge i_clk);

    // Single requests: latency, memory addresses, assembled data, return to idle.
    for (int i = 0; i < 6; i++) begin
      abase = addr_log.size();
      @(negedge i_clk);
      bus.i_req_submit = 1'b1;
      bus.i_req_addr   = vecs[i].addr;
      @(posedge i_clk);
      #1;
      bus.i_req_submit = 1'b0;
      lat = 0;
      while (!bus.o_req_data_valid && lat < 50) begin
        @(posedge i_clk);
        #1;
        lat++;
      end
      check("vec_latency", lat, EXP_LAT);
      check("vec_data", bus.o_req_data, vecs[i].data);
      check("vec_busy_done", o_busy, 0);
      check("vec_addr_count", addr_log.size() - abase, 2);
      if (addr_log.size() - abase == 2) begin
        check("vec_lo_addr", addr_log[abase], vecs[i].lo_addr);
        check("vec_hi_addr", addr_log[abase+1], vecs[i].hi_addr);
      end
      @(posedge i_clk);
      #1;
      check("vec_pulse_one", bus.o_req_data_valid, 0);
      check("vec_data_hold", bus.o_req_data, vecs[i].data);
      repeat (2) @(negedge i_clk);
    end

    // Four back-to-back submits.
    base = resp_q.size();
    @(negedge i_clk);
    for (int i = 1; i <= 4; i++) begin
      bus.i_req_submit = 1'b1;
      bus.i_req_addr   = 16'(i);
      @(negedge i_clk);
    end
    bus.i_req_submit = 1'b0;
    wait_resp(base + 4, 200);
    for (int i = 0; i < 4; i++)
      if (base + i < resp_q.size())
        check("b2b_data", resp_q[base+i], {16'(2*i+5), 16'(2*i+4)} - 32'h00020002);
    check("b2b_overflow", o_overflow, 0);

    // Five submits against a stalled memory: the fifth is dropped.
    do_reset();
    base = resp_q.size();
    hold_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.i_req_submit = 1'b1;
      bus.i_req_addr   = 16'h0011 + 16'(i);
      @(negedge i_clk);
    end
    bus.i_req_submit = 1'b0;
    check("ovf_set", o_overflow, 1);
    check("ovf_busy", o_busy, 1);
    repeat (10) @(negedge i_clk);
    hold_ack = 1'b0;
    wait_resp(base + 4, 200);
    repeat (20) @(negedge i_clk);
    check("ovf_resp_count", resp_q.size() - base, 4);
    check("ovf_sticky", o_overflow, 1);
    for (int i = 0; i < 4; i++)
      if (base + i < resp_q.size())
        check("ovf_data", resp_q[base+i], {16'h0023 + 16'(2*i), 16'h0022 + 16'(2*i)});

    // Full queue: a submit coinciding with a high-word ack is accepted.
    do_reset();
    base = resp_q.size();
    hold_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.i_req_submit = 1'b1;
      bus.i_req_addr   = 16'h0021 + 16'(i);
      @(negedge i_clk);
    end
    bus.i_req_submit = 1'b0;
    hold_ack = 1'b0;
    c = 0;
    while (!(bus.o_mem_req && bus.o_mem_addr[0] && bus.i_mem_ack) && c < 50) begin
      @(negedge i_clk);
      c++;
    end
    check("full_hi_ack_seen", c < 50, 1);
    bus.i_req_submit = 1'b1;
    bus.i_req_addr   = 16'h0025;
    @(negedge i_clk);
    bus.i_req_submit = 1'b0;
    wait_resp(base + 5, 200);
    for (int i = 0; i < 5; i++)
      if (base + i < resp_q.size())
        check("full_data", resp_q[base+i], {16'h0043 + 16'(2*i), 16'h0042 + 16'(2*i)});
    check("full_overflow", o_overflow, 0);

    // Reset during the high-word read, then a stale ack.
    do_reset();
    base = resp_q.size();
    submit(16'h0030);
    c = 0;
    while (!(bus.o_mem_req && bus.o_mem_addr[0]) && c < 20) begin
      @(negedge i_clk);
      c++;
    end
    check("rdhi_seen", c < 20, 1);
    hold_ack = 1'b1;
    #2;
    i_rst = 1'b0;
    #1;
    check("rst_mid_req", bus.o_mem_req, 0);
    check("rst_mid_busy", o_busy, 0);
    @(negedge i_clk);
    i_rst = 1'b1;
    hold_ack = 1'b0;
    stray_ack = 1'b1;
    @(negedge i_clk);
    stray_ack = 1'b0;
    repeat (5) @(negedge i_clk);
    check("stale_no_resp", resp_q.size() - base, 0);
    check("stale_req", bus.o_mem_req, 0);
    check("stale_busy", o_busy, 0);
    submit(16'h0031);
    wait_resp(base + 1, 50);
    if (resp_q.size() > base) check("after_rst_data", resp_q[base], 32'h00630062);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
